// File: rtl/pipeline_control_unit.sv
// Stall/flush sequencer for the 5-stage pipeline: owns PC and pipeline-register enables, bubbles and flushes.
// Optional performance counters are built only when PIPELINE_PERF_COUNTERS_EN is defined.
module pipeline_control_unit #(
    parameter int STALL_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [1:0]       i_hazard_nop,
    input  logic             i_branch_taken_execute,
    input  logic             i_mem_busy,
    output logic             o_pc_enable,
    output logic             o_fetch_decode_enable,
    output logic             o_fetch_decode_flush,
    output logic             o_decode_execute_flush,
    output logic             o_execute_memory_enable,
    output logic             o_memory_writeback_bubble,
    output logic [1:0]       o_ctrl_state,
    output logic [CNT_W-1:0] o_stall_count,
    output logic [CNT_W-1:0] o_flush_count
);

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_STALL    = 2'd1;
    localparam logic [1:0] ST_MEM_WAIT = 2'd2;
    localparam logic [2:0] STALL_RELOAD = 3'(STALL_CYCLES - 1);

    logic [1:0] r_state;
    logic [2:0] r_remaining;
    logic       r_resume_stall;

    logic [1:0] w_state_next;
    logic [2:0] w_remaining_next;
    logic       w_resume_next;
    logic [1:0] w_eval_state;

    always_comb begin
        w_state_next              = r_state;
        w_remaining_next          = r_remaining;
        w_resume_next             = r_resume_stall;
        o_pc_enable               = 1'b1;
        o_fetch_decode_enable     = 1'b1;
        o_fetch_decode_flush      = 1'b0;
        o_decode_execute_flush    = 1'b0;
        o_execute_memory_enable   = 1'b1;
        o_memory_writeback_bubble = 1'b0;

        // The cycle mem_busy drops is evaluated as the state we were frozen out of.
        w_eval_state = r_state;
        if (r_state == ST_MEM_WAIT && !i_mem_busy) begin
            w_eval_state = r_resume_stall ? ST_STALL : ST_RUN;
        end

        if (i_mem_busy) begin
            o_pc_enable               = 1'b0;
            o_fetch_decode_enable     = 1'b0;
            o_execute_memory_enable   = 1'b0;
            o_memory_writeback_bubble = 1'b1;
            w_state_next              = ST_MEM_WAIT;
            if (r_state == ST_RUN) begin
                w_resume_next = 1'b0;
            end else if (r_state == ST_STALL) begin
                w_resume_next = 1'b1;
            end
        end else if (i_branch_taken_execute) begin
            o_fetch_decode_flush   = 1'b1;
            o_decode_execute_flush = 1'b1;
            w_state_next           = ST_RUN;
            w_remaining_next       = 3'd0;
            w_resume_next          = 1'b0;
        end else if (w_eval_state == ST_STALL) begin
            o_pc_enable            = 1'b0;
            o_fetch_decode_enable  = 1'b0;
            o_decode_execute_flush = 1'b1;
            w_resume_next          = 1'b0;
            if (r_remaining <= 3'd1) begin
                w_state_next     = ST_RUN;
                w_remaining_next = 3'd0;
            end else begin
                w_state_next     = ST_STALL;
                w_remaining_next = r_remaining - 3'd1;
            end
        end else if (i_hazard_nop != 2'b00) begin
            o_pc_enable            = 1'b0;
            o_fetch_decode_enable  = 1'b0;
            o_decode_execute_flush = 1'b1;
            w_resume_next          = 1'b0;
            if (STALL_CYCLES > 1) begin
                w_state_next     = ST_STALL;
                w_remaining_next = STALL_RELOAD;
            end else begin
                w_state_next = ST_RUN;
            end
        end else begin
            w_state_next  = ST_RUN;
            w_resume_next = 1'b0;
        end

        // Reset forces the whole pipeline into a safe, fully-bubbled hold.
        if (!i_rst_n) begin
            o_pc_enable               = 1'b0;
            o_fetch_decode_enable     = 1'b0;
            o_fetch_decode_flush      = 1'b1;
            o_decode_execute_flush    = 1'b1;
            o_execute_memory_enable   = 1'b0;
            o_memory_writeback_bubble = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state        <= ST_RUN;
            r_remaining    <= 3'd0;
            r_resume_stall <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            r_remaining    <= w_remaining_next;
            r_resume_stall <= w_resume_next;
        end
    end

    assign o_ctrl_state = r_state;

`ifdef PIPELINE_PERF_COUNTERS_EN
    logic [CNT_W-1:0] r_stall_count;
    logic [CNT_W-1:0] r_flush_count;
    logic             w_branch_set;

    // Only the branch set drives the PC forward while flushing IF/ID.
    assign w_branch_set = o_pc_enable & o_fetch_decode_flush;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_stall_count <= '0;
            r_flush_count <= '0;
        end else begin
            if (!o_pc_enable && r_stall_count != '1) begin
                r_stall_count <= r_stall_count + CNT_W'(1);
            end
            if (w_branch_set && r_flush_count != '1) begin
                r_flush_count <= r_flush_count + CNT_W'(1);
            end
        end
    end

    assign o_stall_count = r_stall_count;
    assign o_flush_count = r_flush_count;
`else
    assign o_stall_count = '0;
    assign o_flush_count = '0;
`endif

endmodule

// File: tb/tb_pipeline_control_unit.sv
// Scoreboard bench for pipeline_control_unit: one instance with STALL_CYCLES=1, one with STALL_CYCLES=3.
// Expected counter values follow PIPELINE_PERF_COUNTERS_EN (zero when the counters are not built).
module tb_pipeline_control_unit;

    localparam logic [5:0] IDLE6 = 6'b110010;
    localparam logic [5:0] STL6  = 6'b000110;
    localparam logic [5:0] BRN6  = 6'b111110;
    localparam logic [5:0] FRZ6  = 6'b000001;
    localparam logic [5:0] RST6  = 6'b001101;

    typedef struct {
        int          sel;
        logic [7:0]  ctl;
        logic [15:0] sc;
        logic [15:0] fc;
        string       name;
    } exp_t;

    logic        clk;
    logic        rstN  [2];
    logic [1:0]  haz   [2];
    logic        br    [2];
    logic        mb    [2];
    logic        pcEn  [2];
    logic        fdEn  [2];
    logic        fdFl  [2];
    logic        deFl  [2];
    logic        emEn  [2];
    logic        mwBub [2];
    logic [1:0]  state [2];
    logic [15:0] scOut [2];
    logic [15:0] fcOut [2];

    exp_t expQ[$];
    int   checks   = 0;
    int   failures = 0;
    int   scModel[2];
    int   fcModel[2];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    pipeline_control_unit #(.STALL_CYCLES(1), .CNT_W(16)) dut1 (
        .i_clk(clk), .i_rst_n(rstN[0]), .i_hazard_nop(haz[0]),
        .i_branch_taken_execute(br[0]), .i_mem_busy(mb[0]),
        .o_pc_enable(pcEn[0]), .o_fetch_decode_enable(fdEn[0]),
        .o_fetch_decode_flush(fdFl[0]), .o_decode_execute_flush(deFl[0]),
        .o_execute_memory_enable(emEn[0]), .o_memory_writeback_bubble(mwBub[0]),
        .o_ctrl_state(state[0]), .o_stall_count(scOut[0]), .o_flush_count(fcOut[0])
    );

    pipeline_control_unit #(.STALL_CYCLES(3), .CNT_W(16)) dut3 (
        .i_clk(clk), .i_rst_n(rstN[1]), .i_hazard_nop(haz[1]),
        .i_branch_taken_execute(br[1]), .i_mem_busy(mb[1]),
        .o_pc_enable(pcEn[1]), .o_fetch_decode_enable(fdEn[1]),
        .o_fetch_decode_flush(fdFl[1]), .o_decode_execute_flush(deFl[1]),
        .o_execute_memory_enable(emEn[1]), .o_memory_writeback_bubble(mwBub[1]),
        .o_ctrl_state(state[1]), .o_stall_count(scOut[1]), .o_flush_count(fcOut[1])
    );

    function automatic logic [7:0] mk(input logic [1:0] s, input logic [5:0] o);
        return {s, o};
    endfunction

    task automatic applyStimulus(input int sel, input logic rn, input logic [1:0] h,
                                 input logic b, input logic m, input logic [7:0] ctl,
                                 input string name);
        exp_t e;
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            rstN[d] = rn ? 1'b1 : 1'b0;
            haz[d]  = 2'b00;
            br[d]   = 1'b0;
            mb[d]   = 1'b0;
        end
        haz[sel] = h;
        br[sel]  = b;
        mb[sel]  = m;
        e.sel  = sel;
        e.ctl  = ctl;
        e.name = name;
`ifdef PIPELINE_PERF_COUNTERS_EN
        e.sc = rn ? 16'(scModel[sel]) : 16'd0;
        e.fc = rn ? 16'(fcModel[sel]) : 16'd0;
`else
        e.sc = 16'd0;
        e.fc = 16'd0;
`endif
        expQ.push_back(e);
        if (!rn) begin
            for (int d = 0; d < 2; d++) begin
                scModel[d] = 0;
                fcModel[d] = 0;
            end
        end else begin
            if (!ctl[5]) scModel[sel]++;
            if (ctl[5] && ctl[3]) fcModel[sel]++;
        end
    endtask

    task automatic checkOutput(input string what, input logic [15:0] act, input logic [15:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h", what, act, expv);
        end
    endtask

    // Monitor: pops one expected response per cycle, sampled mid-cycle.
    initial begin
        exp_t e;
        logic [7:0] act;
        forever begin
            @(negedge clk);
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                act = {state[e.sel], pcEn[e.sel], fdEn[e.sel], fdFl[e.sel],
                       deFl[e.sel], emEn[e.sel], mwBub[e.sel]};
                checkOutput({e.name, " ctl"}, 16'(act), 16'(e.ctl));
                checkOutput({e.name, " stall_count"}, scOut[e.sel], e.sc);
                checkOutput({e.name, " flush_count"}, fcOut[e.sel], e.fc);
            end
        end
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            rstN[d] = 1'b1; haz[d] = 2'b00; br[d] = 1'b0; mb[d] = 1'b0;
            scModel[d] = 0; fcModel[d] = 0;
        end

        applyStimulus(0, 0, 0, 0, 0, mk(0, RST6),  "reset_a");
        applyStimulus(0, 0, 0, 0, 0, mk(0, RST6),  "reset_b");
        applyStimulus(0, 1, 0, 0, 0, mk(0, IDLE6), "idle");

        // STALL_CYCLES=1 instance
        applyStimulus(0, 1, 1, 0, 0, mk(0, STL6),  "lu_h1");
        applyStimulus(0, 1, 0, 0, 0, mk(0, IDLE6), "lu_h1_after");
        applyStimulus(0, 1, 2, 0, 0, mk(0, STL6),  "lu_h2");
        applyStimulus(0, 1, 0, 0, 0, mk(0, IDLE6), "lu_h2_after");
        applyStimulus(0, 1, 3, 0, 0, mk(0, STL6),  "lu_h3_a");
        applyStimulus(0, 1, 3, 0, 0, mk(0, STL6),  "lu_h3_b");
        applyStimulus(0, 1, 0, 0, 0, mk(0, IDLE6), "lu_h3_after");
        applyStimulus(0, 1, 0, 1, 0, mk(0, BRN6),  "branch");
        applyStimulus(0, 1, 0, 0, 0, mk(0, IDLE6), "branch_after");
        applyStimulus(0, 1, 1, 1, 0, mk(0, BRN6),  "br_over_haz");
        applyStimulus(0, 1, 0, 0, 0, mk(0, IDLE6), "br_over_haz_after");
        applyStimulus(0, 1, 0, 1, 1, mk(0, FRZ6),  "mw_br_1");
        applyStimulus(0, 1, 0, 1, 1, mk(2, FRZ6),  "mw_br_2");
        applyStimulus(0, 1, 0, 1, 1, mk(2, FRZ6),  "mw_br_3");
        applyStimulus(0, 1, 0, 1, 1, mk(2, FRZ6),  "mw_br_4");
        applyStimulus(0, 1, 0, 1, 0, mk(2, BRN6),  "mw_br_exit");
        applyStimulus(0, 1, 0, 0, 0, mk(0, IDLE6), "mw_br_after");
        applyStimulus(0, 1, 1, 0, 1, mk(0, FRZ6),  "mw_over_haz");
        applyStimulus(0, 1, 0, 0, 0, mk(2, IDLE6), "mw_exit_idle");
        applyStimulus(0, 1, 0, 0, 0, mk(0, IDLE6), "mw_idle_after");

        // STALL_CYCLES=3 instance
        applyStimulus(1, 1, 1, 0, 0, mk(0, STL6),  "s3_a");
        applyStimulus(1, 1, 0, 0, 0, mk(1, STL6),  "s3_b");
        applyStimulus(1, 1, 0, 0, 0, mk(1, STL6),  "s3_c");
        applyStimulus(1, 1, 0, 0, 0, mk(0, IDLE6), "s3_done");
        applyStimulus(1, 1, 1, 0, 0, mk(0, STL6),  "s3_ign_a");
        applyStimulus(1, 1, 1, 0, 0, mk(1, STL6),  "s3_ign_b");
        applyStimulus(1, 1, 1, 0, 0, mk(1, STL6),  "s3_ign_c");
        applyStimulus(1, 1, 0, 0, 0, mk(0, IDLE6), "s3_ign_done");
        applyStimulus(1, 1, 1, 0, 0, mk(0, STL6),  "s3_mw_a");
        applyStimulus(1, 1, 0, 0, 1, mk(1, FRZ6),  "s3_mw_frz1");
        applyStimulus(1, 1, 0, 0, 1, mk(2, FRZ6),  "s3_mw_frz2");
        applyStimulus(1, 1, 0, 0, 0, mk(2, STL6),  "s3_mw_resume");
        applyStimulus(1, 1, 0, 0, 0, mk(1, STL6),  "s3_mw_last");
        applyStimulus(1, 1, 0, 0, 0, mk(0, IDLE6), "s3_mw_done");
        applyStimulus(1, 1, 0, 0, 1, mk(0, FRZ6),  "s3_mwrun_frz");
        applyStimulus(1, 1, 1, 0, 0, mk(2, STL6),  "s3_mwrun_haz");
        applyStimulus(1, 1, 0, 0, 0, mk(1, STL6),  "s3_mwrun_b");
        applyStimulus(1, 1, 0, 0, 0, mk(1, STL6),  "s3_mwrun_c");
        applyStimulus(1, 1, 0, 0, 0, mk(0, IDLE6), "s3_mwrun_done");
        applyStimulus(1, 1, 1, 0, 0, mk(0, STL6),  "s3_br_a");
        applyStimulus(1, 1, 0, 1, 0, mk(1, BRN6),  "s3_br_in_stall");
        applyStimulus(1, 1, 0, 0, 0, mk(0, IDLE6), "s3_br_done");
        applyStimulus(1, 1, 1, 0, 0, mk(0, STL6),  "s3_rst_a");
        applyStimulus(1, 1, 0, 0, 0, mk(1, STL6),  "s3_rst_b");
        applyStimulus(1, 0, 0, 0, 0, mk(0, RST6),  "s3_rst_mid");
        applyStimulus(1, 1, 0, 0, 0, mk(0, IDLE6), "s3_rst_release");
        applyStimulus(1, 1, 1, 0, 0, mk(0, STL6),  "s3_post_a");
        applyStimulus(1, 1, 0, 0, 0, mk(1, STL6),  "s3_post_b");
        applyStimulus(1, 1, 0, 0, 0, mk(1, STL6),  "s3_post_c");
        applyStimulus(1, 1, 0, 0, 0, mk(0, IDLE6), "s3_post_done");

        for (int i = 0; i < 10 && expQ.size() > 0; i++) @(negedge clk);
        #1;
        checks++;
        if (expQ.size() != 0) begin
            failures++;
            $display("[TB] FAIL drain: %0d responses left, expected 0", expQ.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
